// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the multiplier arbiter.
package mult_arb_pkg;

  localparam int unsigned DefNReq  = 4;
  localparam int unsigned OpWidth  = 8;
  localparam int unsigned ResWidth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StWaitBusy,
    StWaitDone,
    StResult
  } state_e;

endpackage

// File: rtl/mult_arb_if.sv
// Client and multiplier signals of the arbiter, bundled for port connection.
interface mult_arb_if #(
  parameter int unsigned N_REQ = mult_arb_pkg::DefNReq
) ();
  import mult_arb_pkg::*;

  logic [N_REQ-1:0]         req_i;
  logic [OpWidth*N_REQ-1:0] a_i;
  logic [OpWidth*N_REQ-1:0] b_i;
  logic [N_REQ-1:0]         ack_o;
  logic [N_REQ-1:0]         done_o;
  logic [ResWidth-1:0]      y_o;
  logic                     err_o;
  logic                     busy_o;
  logic                     m_start_o;
  logic [OpWidth-1:0]       m_a_o;
  logic [OpWidth-1:0]       m_b_o;
  logic                     m_busy_i;
  logic [ResWidth-1:0]      m_y_i;

  // master: the arbiter itself; slave: the clients and the multiplier around it.
  modport master (
    input  req_i, a_i, b_i, m_busy_i, m_y_i,
    output ack_o, done_o, y_o, err_o, busy_o, m_start_o, m_a_o, m_b_o
  );

  modport slave (
    output req_i, a_i, b_i, m_busy_i, m_y_i,
    input  ack_o, done_o, y_o, err_o, busy_o, m_start_o, m_a_o, m_b_o
  );

endinterface

// File: rtl/mult_arb_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module mult_arb_rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     valid
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned SumW = IdxW + 1;

  logic [SumW-1:0] pos;

  // Scan N_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = {1'b0, ptr} + SumW'(i);
      if (pos >= SumW'(N_REQ)) begin
        pos = pos - SumW'(N_REQ);
      end
      if (!valid && req[pos[IdxW-1:0]]) begin
        valid                = 1'b1;
        idx                  = pos[IdxW-1:0];
        gnt[pos[IdxW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arb.sv
// Round-robin sharing of one sequential 8x8 multiplier between N_REQ clients.
module mult_arb
  import mult_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = DefNReq,
  parameter int unsigned BUSY_TMO = 4
) (
  input logic        clk_i,
  input logic        rst_i,
  mult_arb_if.master bus
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [OpWidth-1:0]  m_a_q, m_a_d;
  logic [OpWidth-1:0]  m_b_q, m_b_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [ResWidth-1:0] y_q, y_d;
  logic                err_q, err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic [N_REQ-1:0]    pick_gnt;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_valid;
  logic [IdxW-1:0]     ptr_next;
  logic [OpWidth-1:0]  a_arr [N_REQ];
  logic [OpWidth-1:0]  b_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign a_arr[k] = bus.a_i[OpWidth*k +: OpWidth];
    assign b_arr[k] = bus.b_i[OpWidth*k +: OpWidth];
  end

  mult_arb_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req  (bus.req_i),
    .ptr  (ptr_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  // Pointer moves just past the requester that was served.
  assign ptr_next = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + IdxW'(1);

  // Next-state logic for the job sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    m_a_d   = m_a_q;
    m_b_d   = m_b_q;
    ack_d   = '0;
    done_d  = '0;
    y_d     = y_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          idx_d   = pick_idx;
          m_a_d   = a_arr[pick_idx];
          m_b_d   = b_arr[pick_idx];
          ack_d   = pick_gnt;
          state_d = StGrant;
        end
      end
      StGrant: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.m_busy_i) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(BUSY_TMO - 1)) begin
          // Multiplier never started: complete the job with a zero result.
          err_d          = 1'b1;
          y_d            = '0;
          done_d[idx_q]  = 1'b1;
          ptr_d          = ptr_next;
          state_d        = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitDone: begin
        if (!bus.m_busy_i) begin
          y_d           = bus.m_y_i;
          done_d[idx_q] = 1'b1;
          state_d       = StResult;
        end
      end
      StResult: begin
        ptr_d   = ptr_next;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      m_a_q   <= '0;
      m_b_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      m_a_q   <= m_a_d;
      m_b_q   <= m_b_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      y_q     <= y_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ack_o     = ack_q;
  assign bus.done_o    = done_q;
  assign bus.y_o       = y_q;
  assign bus.err_o     = err_q;
  assign bus.busy_o    = (state_q != StIdle);
  assign bus.m_start_o = (state_q == StGrant);
  assign bus.m_a_o     = m_a_q;
  assign bus.m_b_o     = m_b_q;

endmodule

// File: doc/mult_arb.md
# mult_arb

Round-robin arbiter and sequencer that shares one 8x8 sequential multiplier (start/busy handshake, 16-bit result) between N_REQ requesters. It accepts operand requests, grants one at a time, pulses the multiplier's start, tracks its busy phase, and returns the product to the granted requester with a one-cycle done strobe. It sits between the client blocks and the single multiplier instance, which lives outside this block.

## Interface
- N_REQ, 4, number of requesters (2..8)
- BUSY_TMO, 4, cycles allowed between m_start_o and first m_busy_i=1 before fault
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- req_i  in  N_REQ  per-requester level request; hold until ack
- a_i  in  8*N_REQ  operand A, requester k at bits [8k+7:8k]
- b_i  in  8*N_REQ  operand B, same packing
- ack_o  out  N_REQ  one-hot, 1-cycle pulse: operands of that requester captured
- done_o  out  N_REQ  one-hot, 1-cycle pulse: y_o valid for that requester
- y_o  out  16  product of last completed job; held until next completion
- err_o  out  1  sticky fault: multiplier never went busy
- busy_o  out  1  arbiter not in IDLE
- m_start_o  out  1  start to multiplier
- m_a_o, m_b_o  out  8 each  operands to multiplier
- m_busy_i  in  1  multiplier busy
- m_y_i  in  16  multiplier result

## Operation
- States: IDLE, GRANT, WAIT_BUSY, WAIT_DONE, RESULT.
- IDLE: if any req_i bit set, pick winner by round-robin starting at pointer ptr (lowest index >= ptr, wrapping); register idx, m_a_o/m_b_o from winner's slice; ack_o[idx]=1 next cycle; -> GRANT.
- GRANT: m_start_o=1 for exactly this cycle; -> WAIT_BUSY.
- WAIT_BUSY: on m_busy_i=1 -> WAIT_DONE; else count; after BUSY_TMO cycles set err_o, pulse done_o[idx] with y_o=0, ptr=idx+1, -> IDLE.
- WAIT_DONE: on m_busy_i=0 -> RESULT capturing y_o<=m_y_i.
- RESULT: done_o[idx]=1; ptr<=(idx+1) mod N_REQ; -> IDLE.
- Requests only sampled in IDLE; dropping req_i before ack cancels it without effect. req_i still high after ack is a new request.
- m_a_o/m_b_o held stable from GRANT through RESULT.
- err_o cleared only by reset.
- Reset: state IDLE, ptr 0, idx 0, all outputs 0 (ack_o, done_o, y_o, err_o, busy_o, m_start_o, m_a_o, m_b_o). Reset mid-job abandons it; no done_o issued. Multiplier shares rst_i.

## Timing
- Edge 0: request seen in IDLE -> GRANT; ack_o high cycle after edge 0; m_start_o high same cycle.
- Multiplier samples start at edge 1, busy for 9 cycles (8 work + 1 ready), low after edge 10.
- Arbiter: WAIT_BUSY after edge 1, WAIT_DONE after edge 2, sees busy low, RESULT after edge 11; done_o high in cycle after edge 11. Request-to-done = 12 edges; next grant earliest after edge 13.
- Throughput: one product per 13 cycles with continuous requests.
- Simultaneous requests: exactly one ack per grant; all N_REQ pending served in N_REQ consecutive jobs, no requester starved.
- ptr wraps N_REQ-1 -> 0.

## Structure
- Package mult_arb_pkg: state enum (3-bit), default N_REQ, operand width 8, result width 16.
- Sub-module rr_pick: combinational N_REQ-bit round-robin selector (req, ptr -> one-hot grant, index, valid).
- FSM, operand muxing, timeout counter, outputs in mult_arb top; multiplier instantiated by parent.

## Test plan
- Single requester 0, a=12, b=10 -> ack_o=0001 after 1 cycle, done_o=0001 12 cycles later, y_o=120, err_o=0.
- All four request together (a=k+1, b=3) from reset -> done order 0,1,2,3, y_o=3,6,9,12, each 13 cycles apart.
- Requester 2 held continuously plus 1 and 3 pulsed -> order 2,3,1(wrapped from ptr),2..., no starvation.
- Multiplier model never asserts busy -> err_o=1 after BUSY_TMO cycles in WAIT_BUSY, done_o pulses with y_o=0, next request still served.
- rst_i low during WAIT_DONE -> all outputs 0 immediately, no done_o; post-reset request for a=255, b=127 -> y_o=32385.
- Requester drops req_i in cycle before IDLE sampling -> no ack, no m_start_o, busy_o stays 0.
